// File: rtl/lcd_byte_arb.sv
// ---------------------------------------------------------------------------
// lcd_byte_arb
//
// Arbitrates several byte-wide LCD command/data streams onto one registered
// output channel. Each input channel presents beats with valid/last flags;
// a multi-beat sequence (first beat with last=0 up to its last=1 beat) is
// forwarded without interleaving beats from any other channel, so a
// controller command and its parameter bytes always arrive back to back.
//
// The output is a single-beat register: a beat accepted on cycle N appears on
// out_data/out_last/out_ch on cycle N+1 and is held there until downstream
// takes it with out_ready. When downstream consumes and a new beat is
// accepted in the same cycle, the block sustains one beat per cycle.
//
// Idle arbitration:
//   default                     fixed priority, lowest valid channel wins
//   LCD_ARB_ROUND_ROBIN_EN      round robin, search starts at a pointer that
//                               moves past the channel of each completed
//                               (last=1) beat
//
// Parameters
//   WIDTH      data bits per channel
//   NCH        number of input channels (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    NCH*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel final-beat-of-sequence flag
//   in_ready   per-channel accept, combinational, at most one bit set
//   out_data   registered selected beat
//   out_valid  out_data holds a beat
//   out_last   registered last flag of the held beat
//   out_ch     source channel of the held beat
//   out_ready  downstream accepts the held beat
// ---------------------------------------------------------------------------
module lcd_byte_arb #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  grant_next;

    logic           reg_free;
    logic [NCH-1:0] scan_valid;
    logic           idle_found;
    logic [CW-1:0]  idle_ofs;
    logic [CW-1:0]  idle_ch;

    logic           sel_active;
    logic [CW-1:0]  sel_ch;
    logic [WIDTH-1:0] sel_data;
    logic           sel_last;
    logic           sel_in_valid;
    logic           accept;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  rr_ptr_next;

    // Channel arithmetic modulo NCH; NCH need not be a power of two, so the
    // natural CW-bit wrap cannot be relied on.
    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base,
                                               input logic [CW-1:0] ofs);
        logic [CW:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= (CW+1)'(NCH)) begin
            sum = sum - (CW+1)'(NCH);
        end
        return sum[CW-1:0];
    endfunction

    // Rotate the valid vector so that bit j is channel (rr_ptr + j) mod NCH;
    // a lowest-index search over the rotated vector is then a round-robin
    // search starting at the pointer.
    always_comb begin
        scan_valid = '0;
        for (int j = 0; j < NCH; j++) begin
            for (int k = 0; k < NCH; k++) begin
                if (wrap_add(rr_ptr, CW'(j)) == CW'(k)) begin
                    scan_valid[j] = in_valid[k];
                end
            end
        end
    end
`else
    assign scan_valid = in_valid;
`endif

    // Lowest set bit of the (possibly rotated) valid vector. Scanning from
    // the top down lets the last hit, i.e. the lowest index, win.
    always_comb begin
        idle_found = 1'b0;
        idle_ofs   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (scan_valid[j]) begin
                idle_found = 1'b1;
                idle_ofs   = CW'(j);
            end
        end
    end

`ifdef LCD_ARB_ROUND_ROBIN_EN
    assign idle_ch = wrap_add(rr_ptr, idle_ofs);
`else
    assign idle_ch = idle_ofs;
`endif

    // While locked only the granted channel is eligible, even when it has
    // nothing to send; that stall is what keeps a sequence contiguous.
    always_comb begin
        sel_active = 1'b0;
        sel_ch     = '0;
        if (state == LOCK) begin
            sel_active = 1'b1;
            sel_ch     = grant;
        end else begin
            sel_active = idle_found;
            sel_ch     = idle_ch;
        end
    end

    // Pick the selected channel's data, last and valid out of the packed
    // input vectors.
    always_comb begin
        sel_data     = '0;
        sel_last     = 1'b0;
        sel_in_valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_ch == CW'(k)) begin
                sel_data     = in_data[k*WIDTH +: WIDTH];
                sel_last     = in_last[k];
                sel_in_valid = in_valid[k];
            end
        end
    end

    assign reg_free = !out_valid || out_ready;
    assign accept   = reg_free && sel_active && sel_in_valid;

    // Ready goes to the selected channel only, and only when the output
    // register can take a beat this cycle.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = reg_free && sel_active && (sel_ch == CW'(k));
        end
    end

    // Next-state logic: a non-final accepted beat locks onto its channel, a
    // final beat releases the lock and (round robin) advances the pointer.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
`ifdef LCD_ARB_ROUND_ROBIN_EN
        rr_ptr_next = rr_ptr;
`endif
        if (accept) begin
            if (sel_last) begin
                state_next  = IDLE;
`ifdef LCD_ARB_ROUND_ROBIN_EN
                rr_ptr_next = wrap_add(sel_ch, CW'(1));
`endif
            end else begin
                state_next = LOCK;
                grant_next = sel_ch;
            end
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
`ifdef LCD_ARB_ROUND_ROBIN_EN
            rr_ptr <= '0;
`endif
        end else begin
            state  <= state_next;
            grant  <= grant_next;
`ifdef LCD_ARB_ROUND_ROBIN_EN
            rr_ptr <= rr_ptr_next;
`endif
        end
    end

    // One-beat output register. Data, last and channel only change on a
    // load, so they stay put while downstream back-pressures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_ch    <= sel_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
